// File: rtl/mode_pkg.sv
// Shared definitions for the system mode controller and its request front-end.
// Holds the controller mode encoding, the request FSM states and button indices.
package mode_pkg;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    PLAY = 2'd1,
    RAW  = 2'd2
  } sysmode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } req_state_t;

  localparam int BTN_EDIT = 0;
  localparam int BTN_PLAY = 1;
  localparam int BTN_RAW  = 2;
  localparam int NUM_BTN  = 3;

  // Fixed priority edit > play > raw, identical to the controller's own priority.
  function automatic sysmode_t pick_target(input logic [NUM_BTN-1:0] pend);
    sysmode_t sel;
    sel = RAW;
    if (pend[BTN_EDIT])      sel = EDIT;
    else if (pend[BTN_PLAY]) sel = PLAY;
    return sel;
  endfunction

  function automatic logic [NUM_BTN-1:0] mode_onehot(input sysmode_t m);
    logic [NUM_BTN-1:0] oh;
    oh = '0;
    case (m)
      EDIT:    oh[BTN_EDIT] = 1'b1;
      PLAY:    oh[BTN_PLAY] = 1'b1;
      RAW:     oh[BTN_RAW]  = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mode_request_gen_if.sv
// Button / controller-facing bundle of the mode request generator.
// master = the request generator, slave = the board plus mode controller side.
interface mode_request_gen_if;

  logic       btn_edit;
  logic       btn_play;
  logic       btn_raw;
  logic [1:0] mode;
  logic       set_edit;
  logic       set_play;
  logic       set_raw;
  logic       busy;
  logic       req_err;

  modport master (
    input  btn_edit, btn_play, btn_raw, mode,
    output set_edit, set_play, set_raw, busy, req_err
  );

  modport slave (
    output btn_edit, btn_play, btn_raw, mode,
    input  set_edit, set_play, set_raw, busy, req_err
  );

endinterface

// File: rtl/mode_request_gen_debounce.sv
// One push-button: 2-flop synchronizer, stable-count debounce and a registered
// single-cycle pulse on each accepted rising level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = r_sync2 ^ r_level;
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  // NOTE: flops use non-blocking assignments so every one samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= w_accept && !r_level;
      if (!w_differ || w_accept) r_cnt <= '0;
      else                       r_cnt <= r_cnt + 1'b1;
      if (w_accept) r_level <= ~r_level;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/mode_request_gen.sv
// Turns three bouncy buttons into single-cycle set_* requests for the mode
// controller, watches mode for the acknowledge and flags timeouts on req_err.
module mode_request_gen
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_TIMEOUT     = 8
) (
  input logic                clk,
  input logic                rst_n,
  mode_request_gen_if.master bus
);

  localparam int                WAIT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  logic [NUM_BTN-1:0] w_btn_in;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] r_pend;
  logic [NUM_BTN-1:0] w_pend_clr;

  req_state_t         r_state;
  req_state_t         w_next;
  sysmode_t           r_target;
  sysmode_t           w_sel;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               w_sel_match;
  logic               w_ack;
  logic               w_timeout;

  logic [NUM_BTN-1:0] w_set;
  logic               w_busy;
  logic               w_err;
  logic [NUM_BTN-1:0] r_set;
  logic               r_busy;
  logic               r_err;

  assign w_btn_in[BTN_EDIT] = bus.btn_edit;
  assign w_btn_in[BTN_PLAY] = bus.btn_play;
  assign w_btn_in[BTN_RAW]  = bus.btn_raw;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .i_btn (w_btn_in[g]),
      .o_rise(w_rise[g])
    );
  end

  assign w_sel       = pick_target(r_pend);
  assign w_sel_match = (bus.mode == w_sel);
  assign w_ack       = (bus.mode == r_target);
  assign w_timeout   = (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (|r_pend && !w_sel_match) w_next = ISSUE;
      ISSUE:    w_next = WAIT_ACK;
      WAIT_ACK: if (w_ack || w_timeout) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_set      = '0;
    w_busy     = 1'b0;
    w_err      = 1'b0;
    w_pend_clr = '0;
    case (r_state)
      IDLE: begin
        // A request for the mode already in force is simply dropped.
        if (|r_pend && w_sel_match) w_pend_clr = mode_onehot(w_sel);
      end
      ISSUE: begin
        w_set      = mode_onehot(r_target);
        w_pend_clr = mode_onehot(r_target);
        w_busy     = 1'b1;
      end
      WAIT_ACK: begin
        w_busy = 1'b1;
        w_err  = !w_ack && w_timeout;
      end
      default: ;
    endcase
  end

  // A fresh press wins over a clear in the same cycle, so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_target   <= EDIT;
      r_wait_cnt <= '0;
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | w_rise;
      if (r_state == IDLE) r_target <= w_sel;
      if (r_state == WAIT_ACK) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                     r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set  <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_set  <= w_set;
      r_busy <= w_busy;
      r_err  <= w_err;
    end
  end

  assign bus.set_edit = r_set[BTN_EDIT];
  assign bus.set_play = r_set[BTN_PLAY];
  assign bus.set_raw  = r_set[BTN_RAW];
  assign bus.busy     = r_busy;
  assign bus.req_err  = r_err;

endmodule

// File: tb/tb_mode_request_gen.sv
// Bench for mode_request_gen: a controller model closes the loop on mode,
// a scoreboard holds the expected pulses and their cycles.
module tb_mode_request_gen;
  import mode_pkg::*;

  localparam int DEB = 4;
  localparam int ACK = 8;

  localparam int K_EDIT = 0;
  localparam int K_PLAY = 1;
  localparam int K_RAW  = 2;
  localparam int K_ERR  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mode_request_gen_if bus();

  mode_request_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .ACK_TIMEOUT    (ACK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: applies set_* with the same priority, or ignores them.
  logic       ctl_en = 1'b1;
  logic       ld     = 1'b0;
  logic [1:0] ld_val = 2'd0;
  logic [1:0] ctl_mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ctl_mode <= EDIT;
    else if (ld)            ctl_mode <= ld_val;
    else if (ctl_en) begin
      if (bus.set_edit)      ctl_mode <= EDIT;
      else if (bus.set_play) ctl_mode <= PLAY;
      else if (bus.set_raw)  ctl_mode <= RAW;
    end
  end

  assign bus.mode = ctl_mode;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t sb[$];
  bit   busy_seen = 1'b0;
  int   busy_last = -1;
  int   n_set;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_pulse_kind", kind, -1);
    end else begin
      e = sb.pop_front();
      check("pulse_kind", kind, e.kind);
      check("pulse_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_set = int'(bus.set_edit) + int'(bus.set_play) + int'(bus.set_raw);
      if (n_set > 1) check("set_onehot", n_set, 1);
      if (n_set == 1) expect_pulse(bus.set_edit ? K_EDIT : (bus.set_play ? K_PLAY : K_RAW));
      if (bus.req_err) expect_pulse(K_ERR);
      if (bus.busy) begin
        busy_seen = 1'b1;
        busy_last = cyc;
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drive_btn(input logic [2:0] b);
    bus.btn_edit = b[BTN_EDIT];
    bus.btn_play = b[BTN_PLAY];
    bus.btn_raw  = b[BTN_RAW];
  endtask

  task automatic load_mode(input logic [1:0] m, input logic en);
    @(negedge clk);
    ld     = 1'b1;
    ld_val = m;
    ctl_en = en;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    busy_seen = 1'b0;
    busy_last = -1;
  endtask

  typedef struct {
    logic [2:0] btn;
    logic [1:0] mode0;
    logic       ctl_on;
    int         k0;
    int         o0;
    int         k1;
    int         o1;
    int         err_off;
    int         busy_off;
    logic [1:0] final_mode;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    // Offsets are in cycles from the first sampling edge of the press.
    vecs[0] = '{3'b010, 2'd0, 1'b1, K_PLAY,  8, -1,  0, -1, 10, 2'd1};
    vecs[1] = '{3'b101, 2'd1, 1'b1, K_EDIT,  8, K_RAW, 12, -1, 14, 2'd2};
    vecs[2] = '{3'b010, 2'd1, 1'b1, -1,      0, -1,  0, -1, -1, 2'd1};
    vecs[3] = '{3'b010, 2'd0, 1'b0, K_PLAY,  8, -1,  0, 16, 16, 2'd0};
    vecs[4] = '{3'b111, 2'd0, 1'b1, K_PLAY,  9, K_RAW, 13, -1, 15, 2'd2};
    vecs[5] = '{3'b001, 2'd2, 1'b1, K_EDIT,  8, -1,  0, -1, 10, 2'd0};

    drive_btn(3'b000);
    repeat (3) @(negedge clk);
    check("rst_set_play", int'(bus.set_play), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_req_err", int'(bus.req_err), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", int'(busy_seen), 0);

    for (int i = 0; i < 6; i++) begin
      load_mode(vecs[i].mode0, vecs[i].ctl_on);
      k = cyc + 1;
      drive_btn(vecs[i].btn);
      if (vecs[i].k0 >= 0)      sb.push_back('{kind: vecs[i].k0, cyc: k + vecs[i].o0});
      if (vecs[i].k1 >= 0)      sb.push_back('{kind: vecs[i].k1, cyc: k + vecs[i].o1});
      if (vecs[i].err_off >= 0) sb.push_back('{kind: K_ERR, cyc: k + vecs[i].err_off});
      wait_until(k + 12);
      drive_btn(3'b000);
      wait_until(k + 40);
      check($sformatf("v%0d_missing_pulses", i), sb.size(), 0);
      sb.delete();
      check($sformatf("v%0d_final_mode", i), int'(bus.mode), int'(vecs[i].final_mode));
      check($sformatf("v%0d_busy_end", i), int'(bus.busy), 0);
      if (vecs[i].busy_off < 0) check($sformatf("v%0d_busy_seen", i), int'(busy_seen), 0);
      else check($sformatf("v%0d_busy_last", i), busy_last, k + vecs[i].busy_off);
    end

    // Glitch one cycle shorter than the debounce window is rejected.
    load_mode(2'd0, 1'b1);
    k = cyc + 1;
    bus.btn_raw = 1'b1;
    wait_until(k + 2);
    bus.btn_raw = 1'b0;
    wait_until(k + 30);
    check("glitch_busy_seen", int'(busy_seen), 0);
    check("glitch_mode", int'(bus.mode), 0);

    // Bounce 1,0,1,0 then hold: one set_raw, timed from the stable level.
    load_mode(2'd0, 1'b1);
    bus.btn_raw = 1'b1; @(negedge clk);
    bus.btn_raw = 1'b0; @(negedge clk);
    bus.btn_raw = 1'b1; @(negedge clk);
    bus.btn_raw = 1'b0; @(negedge clk);
    k = cyc + 1;
    bus.btn_raw = 1'b1;
    sb.push_back('{kind: K_RAW, cyc: k + 8});
    wait_until(k + 12);
    bus.btn_raw = 1'b0;
    wait_until(k + 40);
    check("bounce_missing_pulse", sb.size(), 0);
    sb.delete();
    check("bounce_mode", int'(bus.mode), 2);

    // Reset in WAIT_ACK: outputs clear at once and the timeout never fires.
    load_mode(2'd0, 1'b0);
    k = cyc + 1;
    bus.btn_play = 1'b1;
    sb.push_back('{kind: K_PLAY, cyc: k + 8});
    wait_until(k + 12);
    check("wa_busy_before_rst", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("wa_rst_busy", int'(bus.busy), 0);
    check("wa_rst_set_play", int'(bus.set_play), 0);
    check("wa_rst_req_err", int'(bus.req_err), 0);
    bus.btn_play = 1'b0;
    check("wa_play_seen", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    ctl_en    = 1'b1;
    busy_seen = 1'b0;
    repeat (30) @(negedge clk);
    check("wa_stale_busy", int'(busy_seen), 0);
    check("wa_mode_after_rst", int'(bus.mode), 0);

    // Reset in the middle of a debounce count: nothing comes out afterwards.
    k = cyc + 1;
    bus.btn_raw = 1'b1;
    wait_until(k + 3);
    #2 rst_n = 1'b0;
    #1;
    check("db_rst_busy", int'(bus.busy), 0);
    bus.btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    busy_seen = 1'b0;
    repeat (30) @(negedge clk);
    check("db_stale_busy", int'(busy_seen), 0);

    // A fresh press after reset behaves normally.
    load_mode(2'd0, 1'b1);
    k = cyc + 1;
    bus.btn_play = 1'b1;
    sb.push_back('{kind: K_PLAY, cyc: k + 8});
    wait_until(k + 12);
    bus.btn_play = 1'b0;
    wait_until(k + 40);
    check("after_rst_missing_pulse", sb.size(), 0);
    sb.delete();
    check("after_rst_mode", int'(bus.mode), 1);
    check("after_rst_busy_last", busy_last, k + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
